// File: rtl/bsg_bladerunner_rom_reader_if.sv
// Request / response / output-stream bundle between the ROM reader, the manycore endpoint
// and the downstream consumer.
interface bsg_bladerunner_rom_reader_if #(
  parameter int x_cord_width_p  = 4,
  parameter int y_cord_width_p  = 4,
  parameter int addr_width_p    = 16,
  parameter int data_width_p    = 32,
  parameter int load_id_width_p = 2
);
  logic                         out_v_o;
  logic                         out_ready_i;
  logic [addr_width_p-1:0]      out_addr_o;
  logic                         out_we_o;
  logic [(data_width_p>>3)-1:0] out_mask_o;
  logic [x_cord_width_p-1:0]    out_x_o;
  logic [y_cord_width_p-1:0]    out_y_o;
  logic [load_id_width_p-1:0]   out_load_id_o;

  logic                         returned_v_i;
  logic [data_width_p-1:0]      returned_data_i;
  logic [load_id_width_p-1:0]   returned_load_id_i;
  logic                         returned_yumi_o;

  logic                         data_v_o;
  logic [data_width_p-1:0]      data_o;
  logic                         data_ready_i;

  modport master (
    output out_v_o, out_addr_o, out_we_o, out_mask_o, out_x_o, out_y_o, out_load_id_o,
    output returned_yumi_o, data_v_o, data_o,
    input  out_ready_i, returned_v_i, returned_data_i, returned_load_id_i, data_ready_i
  );

  modport slave (
    input  out_v_o, out_addr_o, out_we_o, out_mask_o, out_x_o, out_y_o, out_load_id_o,
    input  returned_yumi_o, data_v_o, data_o,
    output out_ready_i, returned_v_i, returned_data_i, returned_load_id_i, data_ready_i
  );
endinterface

// File: rtl/bsg_bladerunner_rom_reader.sv
// Issues a windowed burst of remote word loads to one tile and reorders the returned words
// into an in-order output stream.
module bsg_bladerunner_rom_reader #(
  parameter int x_cord_width_p  = 4,
  parameter int y_cord_width_p  = 4,
  parameter int addr_width_p    = 16,
  parameter int data_width_p    = 32,
  parameter int load_id_width_p = 2,
  parameter int window_els_p    = 4,
  parameter int count_width_p   = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      start_i,
  input  logic [addr_width_p-1:0]   base_addr_i,
  input  logic [count_width_p-1:0]  count_i,
  input  logic [x_cord_width_p-1:0] dest_x_i,
  input  logic [y_cord_width_p-1:0] dest_y_i,
  output logic                      busy_o,
  output logic                      done_o,
  bsg_bladerunner_rom_reader_if.master bus
);

  localparam int win_bits_lp = $clog2(window_els_p);
  localparam logic [count_width_p-1:0] cnt_one_lp    = 1;
  localparam logic [count_width_p-1:0] window_cnt_lp = window_els_p;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                      state_reg, state_next;
  logic [addr_width_p-1:0]     base_reg;
  logic [count_width_p-1:0]    count_reg, issue_cnt_reg, drain_cnt_reg, in_flight;
  logic [x_cord_width_p-1:0]   x_reg;
  logic [y_cord_width_p-1:0]   y_reg;
  logic [window_els_p-1:0]     slot_valid;
  logic [data_width_p-1:0]     slot_data [window_els_p];
  logic [win_bits_lp-1:0]      issue_slot, drain_slot, ret_slot;
  logic                        in_run, issue_fire, drain_fire, rsp_write;

  assign in_run     = (state_reg == RUN);
  assign in_flight  = issue_cnt_reg - drain_cnt_reg;
  assign issue_slot = issue_cnt_reg[win_bits_lp-1:0];
  assign drain_slot = drain_cnt_reg[win_bits_lp-1:0];
  assign ret_slot   = bus.returned_load_id_i[win_bits_lp-1:0];

  assign busy_o = in_run;
  assign done_o = (state_reg == DONE);

  assign bus.out_v_o         = in_run && (issue_cnt_reg < count_reg) && (in_flight < window_cnt_lp);
  assign bus.out_addr_o      = base_reg + addr_width_p'(issue_cnt_reg);
  assign bus.out_we_o        = 1'b0;
  assign bus.out_mask_o      = '1;
  assign bus.out_x_o         = x_reg;
  assign bus.out_y_o         = y_reg;
  assign bus.out_load_id_o   = load_id_width_p'(issue_slot);
  assign bus.returned_yumi_o = bus.returned_v_i;
  assign bus.data_v_o        = in_run && slot_valid[drain_slot];
  assign bus.data_o          = slot_data[drain_slot];

  assign issue_fire = bus.out_v_o && bus.out_ready_i;
  assign drain_fire = bus.data_v_o && bus.data_ready_i;
  // Responses outside RUN belong to an aborted or finished transfer and are dropped.
  assign rsp_write  = in_run && bus.returned_v_i;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start_i) state_next = (count_i == '0) ? DONE : RUN;
      RUN:  if (drain_fire && (drain_cnt_reg + cnt_one_lp == count_reg)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      count_reg     <= '0;
      issue_cnt_reg <= '0;
      drain_cnt_reg <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start_i) begin
        base_reg      <= base_addr_i;
        count_reg     <= count_i;
        x_reg         <= dest_x_i;
        y_reg         <= dest_y_i;
        issue_cnt_reg <= '0;
        drain_cnt_reg <= '0;
      end else begin
        if (issue_fire) issue_cnt_reg <= issue_cnt_reg + cnt_one_lp;
        if (drain_fire) drain_cnt_reg <= drain_cnt_reg + cnt_one_lp;
      end
    end
  end

  // Reorder slots: the window guarantees a write and a drain never target the same slot.
  for (genvar gi = 0; gi < window_els_p; gi++) begin : g_slot
    logic                    valid_reg;
    logic [data_width_p-1:0] data_reg;
    logic                    wr, clr;

    assign wr  = rsp_write && (ret_slot == win_bits_lp'(gi));
    assign clr = drain_fire && (drain_slot == win_bits_lp'(gi));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
      end else if (wr) begin
        valid_reg <= 1'b1;
        data_reg  <= bus.returned_data_i;
      end else if (clr) begin
        valid_reg <= 1'b0;
      end
    end

    assign slot_valid[gi] = valid_reg;
    assign slot_data[gi]  = data_reg;
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (load_id_width_p >= win_bits_lp)
        else $error("rom_reader: load_id_width_p too small for window_els_p");
      if (rsp_write)
        assert (!slot_valid[ret_slot])
          else $error("rom_reader: response to occupied slot %0d", ret_slot);
    end
  end

endmodule

// File: tb/tb_bsg_bladerunner_rom_reader.sv
// Directed and randomized transfers against a word-level model of the expected request
// sequence and in-order output stream.
module tb_bsg_bladerunner_rom_reader;

  localparam int XW = 4, YW = 4, AW = 8, DW = 32, LW = 2, WIN = 4, CW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_in;
  logic [CW-1:0] count_in;
  logic [XW-1:0] dx;
  logic [YW-1:0] dy;
  logic          busy, done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bsg_bladerunner_rom_reader_if #(
    .x_cord_width_p(XW), .y_cord_width_p(YW), .addr_width_p(AW),
    .data_width_p(DW), .load_id_width_p(LW)
  ) bus ();

  bsg_bladerunner_rom_reader #(
    .x_cord_width_p(XW), .y_cord_width_p(YW), .addr_width_p(AW), .data_width_p(DW),
    .load_id_width_p(LW), .window_els_p(WIN), .count_width_p(CW)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .base_addr_i(base_in),
    .count_i(count_in), .dest_x_i(dx), .dest_y_i(dy), .busy_o(busy), .done_o(done),
    .bus(bus)
  );

  // ROM contents seen by the responder: distinct, address-derived words.
  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return {8'hC3, a, ~a, a ^ 8'h5A};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // mode 0: in-order responder; 1: random order and delay; 2: hold until 4 pending, then
  // return issue indices 2,0,3,1; 3: scripted window stall (index 1 at cycle 10, 0 at 13).
  task automatic run_xfer(input logic [7:0] b, input int cnt, input logic [3:0] x,
                          input logic [3:0] y, input int mode, input int oready_pct,
                          input int dready_pct, input int stall_at);
    int         n_iss, n_drn, cyc, drive_k, perm_pos, pick, want_k;
    bit         arrived [64];
    int         pend_k [$];
    logic [1:0] pend_id [$];
    logic [7:0] pend_a [$];
    logic [7:0] ea;
    logic       exp_v;
    foreach (arrived[i]) arrived[i] = 1'b0;
    n_iss = 0; n_drn = 0; cyc = 0; drive_k = -1; perm_pos = 0;
    start = 1'b1; base_in = b; count_in = 16'(cnt); dx = x; dy = y;
    @(posedge clk); #1;
    while (n_drn < cnt && cyc < 3000) begin
      if (drive_k >= 0) arrived[drive_k] = 1'b1;
      drive_k  = -1;
      start    = 1'($urandom_range(0, 1));
      base_in  = 8'($urandom);
      count_in = 16'($urandom_range(0, 5));
      bus.out_ready_i  = ($urandom_range(0, 99) < oready_pct);
      bus.data_ready_i = ($urandom_range(0, 99) < dready_pct) &&
                         !(cyc >= stall_at && cyc < stall_at + 10);
      pick = -1; want_k = -1;
      case (mode)
        0: if (pend_k.size() > 0) pick = 0;
        1: if (pend_k.size() > 0 && $urandom_range(0, 9) < 6)
             pick = $urandom_range(0, pend_k.size() - 1);
        2: if (perm_pos < 4 && (perm_pos > 0 || pend_k.size() == 4)) begin
             case (perm_pos)
               0: want_k = 2;
               1: want_k = 0;
               2: want_k = 3;
               default: want_k = 1;
             endcase
             perm_pos++;
           end
        default: begin
          if (cyc == 10) want_k = 1;
          else if (cyc == 13) want_k = 0;
          else if (cyc >= 16 && pend_k.size() > 0) pick = 0;
        end
      endcase
      if (want_k >= 0)
        for (int i = 0; i < pend_k.size(); i++) if (pend_k[i] == want_k) pick = i;
      if (pick >= 0) begin
        drive_k = pend_k[pick];
        bus.returned_v_i       = 1'b1;
        bus.returned_load_id_i = pend_id[pick];
        bus.returned_data_i    = rom_word(pend_a[pick]);
        pend_k.delete(pick); pend_id.delete(pick); pend_a.delete(pick);
      end else begin
        bus.returned_v_i       = 1'b0;
        bus.returned_load_id_i = 2'($urandom);
        bus.returned_data_i    = $urandom;
      end
      @(negedge clk);
      check("busy", busy, 1);
      check("done_low", done, 0);
      check("yumi", bus.returned_yumi_o, bus.returned_v_i);
      exp_v = (n_iss < cnt) && (n_iss - n_drn < WIN);
      check("out_v", bus.out_v_o, exp_v);
      if (bus.out_v_o) begin
        ea = b + 8'(n_iss);
        check("out_addr", bus.out_addr_o, ea);
        check("out_id", bus.out_load_id_o, n_iss % WIN);
        check("out_x", bus.out_x_o, x);
        check("out_y", bus.out_y_o, y);
        check("out_we", bus.out_we_o, 0);
        check("out_mask", bus.out_mask_o, 4'hF);
      end
      check("data_v", bus.data_v_o, (n_drn < cnt) ? arrived[n_drn] : 1'b0);
      if (bus.data_v_o) begin
        ea = b + 8'(n_drn);
        check("data", bus.data_o, rom_word(ea));
      end
      if (bus.out_v_o && bus.out_ready_i) begin
        pend_k.push_back(n_iss);
        pend_id.push_back(bus.out_load_id_o);
        pend_a.push_back(bus.out_addr_o);
        n_iss++;
      end
      if (bus.data_v_o && bus.data_ready_i) n_drn++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.returned_v_i = 1'b0;
    start = 1'b0;
    check("drained", n_drn, cnt);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("out_v_done", bus.out_v_o, 0);
    check("data_v_done", bus.data_v_o, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_after", done, 0);
    check("busy_after", busy, 0);
    @(posedge clk); #1;
    $display("xfer base=%0h count=%0d mode=%0d cycles=%0d drained=%0d", b, cnt, mode, cyc, n_drn);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; base_in = '0; count_in = '0; dx = '0; dy = '0;
    bus.out_ready_i = 1'b0; bus.returned_v_i = 1'b1; bus.returned_data_i = '1;
    bus.returned_load_id_i = '0; bus.data_ready_i = 1'b1;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_v", bus.out_v_o, 0);
    check("rst_addr", bus.out_addr_o, 0);
    check("rst_id", bus.out_load_id_o, 0);
    check("rst_we", bus.out_we_o, 0);
    check("rst_mask", bus.out_mask_o, 4'hF);
    check("rst_xy", {bus.out_x_o, bus.out_y_o}, 0);
    check("rst_data_v", bus.data_v_o, 0);
    check("rst_data", bus.data_o, 0);
    check("rst_yumi", bus.returned_yumi_o, 1);
    $display("reset state checked");
    bus.returned_v_i = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_xfer(8'h10, 3, 4'h5, 4'hA, 0, 100, 100, -100);
    run_xfer(8'h40, 8, 4'h2, 4'h3, 3, 100, 100, -100);
    run_xfer(8'h80, 4, 4'h1, 4'h1, 2, 100, 100, -100);
    run_xfer(8'h20, 12, 4'h7, 4'h7, 0, 100, 100, 3);
    run_xfer(8'hFE, 4, 4'h3, 4'hC, 0, 100, 100, -100);

    // zero-length transfer
    start = 1'b1; base_in = 8'h55; count_in = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_out_v", bus.out_v_o, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("zero_done_after", done, 0);
    @(posedge clk); #1;
    $display("zero-length transfer checked");

    // abort mid-transfer, then a late response while idle
    start = 1'b1; base_in = 8'h30; count_in = 16'd8; bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_out_v", bus.out_v_o, 0);
    check("abort_done", done, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.returned_v_i = 1'b1; bus.returned_load_id_i = 2'd0; bus.returned_data_i = 32'hDEADBEEF;
    @(negedge clk);
    check("late_yumi", bus.returned_yumi_o, 1);
    check("late_data_v", bus.data_v_o, 0);
    check("late_busy", busy, 0);
    @(posedge clk); #1;
    bus.returned_v_i = 1'b0;
    @(negedge clk);
    check("late_data_v2", bus.data_v_o, 0);
    check("late_done", done, 0);
    @(posedge clk); #1;
    $display("abort and late response checked");
    run_xfer(8'h30, 6, 4'h9, 4'h4, 0, 100, 100, -100);

    for (int t = 0; t < 8; t++)
      run_xfer(8'($urandom), $urandom_range(1, 30), 4'($urandom), 4'($urandom), 1,
               $urandom_range(40, 100), $urandom_range(40, 100), $urandom_range(0, 30));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
